// File: rtl/proto_serialize.sv
// Protobuf wire-format encoder: turns field commands plus payload bytes into an
// encoded byte stream behind a single valid/ready output register.
module proto_serialize #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             field_valid_i,
    output logic             field_ready_o,
    input  logic [4:0]       field_num_i,
    input  logic [2:0]       wire_type_i,
    input  logic [63:0]      value_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             hdr_only_i,
    input  logic             pl_valid_i,
    input  logic [7:0]       pl_data_i,
    output logic             pl_ready_o,
    output logic             out_valid_o,
    output logic [7:0]       out_data_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             err_o
);

    // Counter covers both the fixed byte count (up to 8) and the payload length.
    localparam int unsigned CNT_W = (LEN_W > 4) ? LEN_W : 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_VARINT,
        S_FIXED,
        S_LEN,
        S_PAYLOAD
    } state_e;

    state_e           state_q, state_d;
    logic [63:0]      r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       wt_q, wt_d;
    logic [7:0]       key_q, key_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             hdr_q, hdr_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             err_q, err_d;
    logic             slot_free;
    logic             cmd_bad;
    logic             varint_done;

    function automatic state_e after_key(input logic [2:0] wt);
        case (wt)
            3'd0:    after_key = S_VARINT;
            3'd2:    after_key = S_LEN;
            default: after_key = S_FIXED;
        endcase
    endfunction

    assign slot_free     = !out_valid_q || out_ready_i;
    assign cmd_bad       = !(wire_type_i inside {3'd0, 3'd1, 3'd2, 3'd5}) || (field_num_i == 5'd0);
    assign varint_done   = (r_q[63:7] == 57'd0);
    assign field_ready_o = (state_q == S_IDLE);
    assign pl_ready_o    = (state_q == S_PAYLOAD) && slot_free;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_last_o    = out_last_q;
    assign err_o         = err_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            cnt_q       <= '0;
            wt_q        <= '0;
            key_q       <= '0;
            len_q       <= '0;
            hdr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            wt_q        <= wt_d;
            key_q       <= key_d;
            len_q       <= len_d;
            hdr_q       <= hdr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    // Next-state and output-register load; a byte loads only when the slot is free.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        wt_d        = wt_q;
        key_d       = key_q;
        len_d       = len_q;
        hdr_d       = hdr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;

        if (slot_free) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (field_valid_i) begin
                    wt_d  = wire_type_i;
                    key_d = {field_num_i, wire_type_i};
                    len_d = len_i;
                    hdr_d = hdr_only_i;
                    r_d   = (wire_type_i == 3'd2) ? 64'(len_i) : value_i;
                    cnt_d = (wire_type_i == 3'd1) ? CNT_W'(8) : CNT_W'(4);
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else if (slot_free) begin
                        out_valid_d = 1'b1;
                        out_data_d  = {field_num_i, wire_type_i};
                        state_d     = after_key(wire_type_i);
                    end else begin
                        state_d = S_KEY;
                    end
                end
            end
            S_KEY: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = key_q;
                    state_d     = after_key(wt_q);
                end
            end
            S_VARINT: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {!varint_done, r_q[6:0]};
                    r_d         = r_q >> 7;
                    if (varint_done) begin
                        out_last_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_FIXED: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = r_q[7:0];
                    r_d         = r_q >> 8;
                    cnt_d       = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        out_last_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_LEN: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {!varint_done, r_q[6:0]};
                    r_d         = r_q >> 7;
                    if (varint_done) begin
                        if (hdr_q || (len_q == '0)) begin
                            out_last_d = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            cnt_d   = CNT_W'(len_q);
                            state_d = S_PAYLOAD;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (pl_valid_i && slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pl_data_i;
                    cnt_d       = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        out_last_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/proto_serialize.md
Name: proto_serialize

Overview:
Protobuf wire-format encoder: the transmit counterpart of the stream deserializer. It accepts one field command per handshake (field number, wire type, value or length) and emits the encoded bytes (key, varint/fixed payload, length prefix, pass-through payload bytes) on a byte stream with valid/ready backpressure. Embedded messages are sent as a header-only length-delimited command followed by the inner field commands. The upstream message builder computes embedded-message lengths.

Parameters:
LEN_W, 8, width of length-delimited length field; legal 1..32; the length is varint-encoded, so it takes 1..5 bytes.

Ports:
clk_i  in  1  clock
reset_ni  in  1  synchronous active-low reset
field_valid_i  in  1  field command valid
field_ready_o  out  1  field command accepted when valid&ready
field_num_i  in  5  protobuf field number (1..31); key is always one byte
wire_type_i  in  3  0=VARINT, 1=FIXED64, 2=LENGTH_DELIMITED, 5=FIXED32
value_i  in  64  varint/fixed value (fixed32 uses [31:0])
len_i  in  LEN_W  payload length for wire type 2
hdr_only_i  in  1  wire type 2 only: emit key+length, skip payload phase (embedded message header)
pl_valid_i  in  1  payload byte valid
pl_data_i  in  8  payload byte
pl_ready_o  out  1  payload byte accepted when valid&ready
out_valid_o  out  1  encoded byte valid
out_data_o  out  8  encoded byte
out_ready_i  in  1  downstream ready
out_last_o  out  1  marks final byte of current field
err_o  out  1  one-cycle pulse: rejected command

Behaviour:
- Reset (reset_ni=0 at a clk_i edge): state=IDLE; out_valid_o=0, out_data_o=0, out_last_o=0, err_o=0. Reset mid-field discards all remaining bytes. No partial resume.
- Single output register. It loads a new byte when !out_valid_o || out_ready_i ("slot free"). out_valid_o/out_data_o/out_last_o are held stable while out_valid_o && !out_ready_i.
- field_ready_o = (state==IDLE). Command accepted at edge N → key byte {field_num_i, wire_type_i} valid at N+1. Command fields are captured at acceptance.
- Rejects: wire_type ∈ {3,4,6,7} or field_num_i==0 → command consumed, err_o=1 at N+1, nothing emitted, stay IDLE.
- States: IDLE → KEY → {VARINT | FIXED | LEN} → (PAYLOAD) → IDLE. Each output-byte state advances only when the slot is free.
- VARINT: holds a 64-bit remainder r. Byte = {|r[63:7], r[6:0]}. On load, r <= r>>7. The field ends on the byte with MSB 0. Value 0 → single 0x00. Maximum is 10 bytes.
- FIXED: emits 8 (wt 1) or 4 (wt 5) bytes little-endian from value_i.
- LEN: encodes len_i as a varint using the same rule.
  - Afterwards: if hdr_only_i or len_i==0 → IDLE, and the last length byte carries out_last_o.
  - Otherwise → PAYLOAD with count=len_i.
- PAYLOAD: pl_ready_o = (state==PAYLOAD) && slot free. This is combinational from registers and out_ready_i; no combinational path from pl_valid_i.
  - Each accepted byte is copied to the output register and count decrements.
  - At count==1 the byte carries out_last_o, and the next state is IDLE.
  - Stalls indefinitely on pl_valid_i=0.
- out_last_o asserts only with out_valid_o, on the final byte of a field. For hdr_only it is the final length byte.
- Back-to-back: IDLE accepts a new command at the same edge that loads the last byte of the previous field. Throughput is 1 byte/clock under continuous ready, including command turnaround.
- pl_valid_i outside PAYLOAD is ignored (pl_ready_o=0).
- err_o never coincides with a new byte load.

Test Plan:
- Field 1, VARINT, value 150, out_ready_i=1 → 0x08, 0x96, 0x01 on consecutive cycles starting N+1; out_last_o on 0x01 only; field_ready_o high again on the edge that loads 0x01.
- Field 2, LEN_DELIM, len 3, payload 0x61,0x62,0x63 with pl_valid_i gapped every other cycle → 0x12, 0x03, 0x61, 0x62, 0x63; out_last_o on 0x63; no byte duplicated or dropped.
- VARINT value 0xFFFF_FFFF_FFFF_FFFF, out_ready_i pseudo-random 50% → key, 9×0xFF, 0x01; data/last held stable across every stall; value 0 → key, 0x00 (last).
- Field 5 FIXED32, value 0x12345678 → 0x2D, 0x78, 0x56, 0x34, 0x12; field 4 FIXED64, value 0x0102030405060708 → 0x21, then 0x08 … 0x01.
- Field 3, hdr_only, len 200 → 0x1A, 0xC8, 0x01 (last), pl_ready_o never asserted. Then field 3, len 0, not hdr_only → 0x1A, 0x00 (last).
- Error and reset cases:
  - wire_type 3, and separately field_num 0 → err_o pulse at N+1, no output, next command accepted.
  - reset_ni=0 mid-PAYLOAD → out_valid_o=0 and state IDLE after the edge; a fresh field encodes correctly afterward.
